seq_subtractor: RTL and testbench

SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

---
 rtl/seq_sub_pkg.sv | 13 +
 rtl/fs_slice.sv | 25 ++
 rtl/seq_subtractor.sv | 124 ++++++++++++
 tb/tb_seq_subtractor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_sub_pkg.sv
// Shared definitions for the digit-serial subtractor: controller states and default geometry.
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

endpackage

// File: rtl/fs_slice.sv
// One DIGIT-bit slice of a ripple-borrow subtractor, purely combinational.
module fs_slice
  import seq_sub_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bi,
  output logic [DIGIT-1:0] diff,
  output logic             bo
);

  logic [DIGIT:0] brw;

  assign brw[0] = bi;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign diff[i]   = a[i] ^ b[i] ^ brw[i];
    assign brw[i+1]  = (~a[i] & b[i]) | (brw[i] & (~a[i] | b[i]));
  end

  assign bo = brw[DIGIT];

endmodule

// File: rtl/seq_subtractor.sv
// Digit-serial subtractor: x - y - bin, one DIGIT-bit slice per clock, LSB first.
// Result appears NDIG edges after the accepting edge; d/bout/ovf hold until the next completion.
module seq_subtractor
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state, nstate;
  logic             accept, last;
  logic [WIDTH-1:0] xr, yr, wr, wr_nxt;
  logic             br;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] sa, sb, sd;
  logic             sbo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    accept = 1'b0;
    last   = 1'b0;
    case (state)
      IDLE: if (start) begin
        nstate = RUN;
        accept = 1'b1;
      end
      RUN: if (cnt == LAST) begin
        nstate = DONE;
        last   = 1'b1;
      end
      DONE: if (start) begin
        nstate = RUN;
        accept = 1'b1;
      end else begin
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Operand slice feeding the subtractor cell, selected by the digit counter.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt == i[CW-1:0]) begin
        sa = xr[i*DIGIT +: DIGIT];
        sb = yr[i*DIGIT +: DIGIT];
      end
    end
  end

  fs_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (sa),
    .b    (sb),
    .bi   (br),
    .diff (sd),
    .bo   (sbo)
  );

  always_comb begin
    wr_nxt = wr;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt == i[CW-1:0]) wr_nxt[i*DIGIT +: DIGIT] = sd;
    end
  end

  // Working register wr is kept apart from d so the visible result only moves on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      xr   <= '0;
      yr   <= '0;
      wr   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else begin
      busy <= (nstate == RUN);
      done <= (nstate == DONE);
      if (accept) begin
        xr  <= x;
        yr  <= y;
        br  <= bin;
        cnt <= '0;
        wr  <= '0;
      end else if (state == RUN) begin
        wr  <= wr_nxt;
        br  <= sbo;
        cnt <= cnt + 1'b1;
        if (last) begin
          d    <= wr_nxt;
          bout <= sbo;
          ovf  <= (xr[WIDTH-1] != yr[WIDTH-1]) && (wr_nxt[WIDTH-1] != xr[WIDTH-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_subtractor.sv
// Self-checking bench: directed table, hand-written corner sequences, random ops on DIGIT=4/1/16 builds.
module tb_seq_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        bin = 1'b0;
  logic [15:0] x = '0, y = '0;

  logic        busy, done, bout, ovf;
  logic [15:0] d;
  logic        busy1, done1, bout1, ovf1;
  logic [15:0] d1;
  logic        busy16, done16, bout16, ovf16;
  logic [15:0] d16;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  seq_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf)
  );

  seq_subtractor #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .bin(bin),
    .busy(busy1), .done(done1), .d(d1), .bout(bout1), .ovf(ovf1)
  );

  seq_subtractor #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .bin(bin),
    .busy(busy16), .done(done16), .d(d16), .bout(bout16), .ovf(ovf16)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        bin;
    logic [15:0] ed;
    logic        eb;
    logic        eo;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for d/borrow, signed range test for overflow.
  function automatic void model(input logic [15:0] ox, input logic [15:0] oy, input logic ob,
                                output logic [15:0] ed, output logic eb, output logic eo);
    int ux, uy, sx, sy, ur, sr;
    ux = int'(ox);
    uy = int'(oy);
    sx = int'($signed(ox));
    sy = int'($signed(oy));
    ur = ux - uy - int'(ob);
    sr = sx - sy - int'(ob);
    ed = 16'(ur & 32'hFFFF);
    eb = (ur < 0);
    eo = (sr > 32767) || (sr < -32768);
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Start one op at a falling edge and follow all three builds to completion.
  task automatic run_op(input logic [15:0] ox, input logic [15:0] oy, input logic ob,
                        input logic [15:0] ed, input logic eb, input logic eo, input string tag);
    int l4, l1, l16, bc;
    l4 = 0; l1 = 0; l16 = 0; bc = 0;
    x = ox; y = oy; bin = ob; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (busy && l4 == 0) bc++;
      if (done && l4 == 0) l4 = n;
      if (done1 && l1 == 0) l1 = n;
      if (done16 && l16 == 0) l16 = n;
      if (l4 != 0 && l1 != 0 && l16 != 0) break;
      x = 16'($urandom); y = 16'($urandom); bin = 1'($urandom);
      @(posedge clk); @(negedge clk);
    end
    chk({tag, " latency d4"}, 32'(l4), 32'd5);
    chk({tag, " latency d1"}, 32'(l1), 32'd17);
    chk({tag, " latency d16"}, 32'(l16), 32'd2);
    chk({tag, " busy cycles"}, 32'(bc), 32'd4);
    chk({tag, " d"}, 32'(d), 32'(ed));
    chk({tag, " bout"}, 32'(bout), 32'(eb));
    chk({tag, " ovf"}, 32'(ovf), 32'(eo));
    chk({tag, " d1"}, 32'(d1), 32'(ed));
    chk({tag, " bout1"}, 32'(bout1), 32'(eb));
    chk({tag, " ovf1"}, 32'(ovf1), 32'(eo));
    chk({tag, " d16"}, 32'(d16), 32'(ed));
    chk({tag, " bout16"}, 32'(bout16), 32'(eb));
    chk({tag, " ovf16"}, 32'(ovf16), 32'(eo));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] ed;
    logic        eb, eo;
    int          cnt;

    tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tbl[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[7] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0};
    tbl[8] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1};

    #1 rst_n = 1'b0;
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset d", 32'(d), 32'd0);
    chk("reset bout", 32'(bout), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First vector starts on the very first edge after reset release.
    for (int i = 0; i < 9; i++)
      run_op(tbl[i].x, tbl[i].y, tbl[i].bin, tbl[i].ed, tbl[i].eb, tbl[i].eo, $sformatf("vec%0d", i));

    // Start during RUN is ignored; start during DONE chains a second op.
    do_reset();
    x = 16'h00FF; y = 16'h000F; bin = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    x = 16'hFFFF;
    @(posedge clk); @(negedge clk);
    start = 1'b0; x = 16'h0000;
    cnt = 0;
    while (!done && cnt < 20) begin
      @(posedge clk); @(negedge clk);
      cnt++;
    end
    chk("midrun done seen", 32'(done), 32'd1);
    chk("midrun ignored d", 32'(d), 32'h00F0);
    x = 16'h0010; y = 16'h0001; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("chain busy", 32'(busy), 32'd1);
    chk("chain done low", 32'(done), 32'd0);
    chk("chain d held", 32'(d), 32'h00F0);
    cnt = 1;
    while (!done && cnt < 20) begin
      @(posedge clk); @(negedge clk);
      cnt++;
    end
    chk("chain done edges", 32'(cnt), 32'd5);
    chk("chain d", 32'(d), 32'h000F);

    // Reset in the middle of a run.
    @(negedge clk);
    x = 16'h1234; y = 16'h0234; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset d", 32'(d), 32'd0);
    chk("midreset bout", 32'(bout), 32'd0);
    chk("midreset ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("midreset no resume", 32'(cnt), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] rx, ry;
      logic        rb;
      rx = pick();
      ry = pick();
      rb = 1'($urandom);
      model(rx, ry, rb, ed, eb, eo);
      run_op(rx, ry, rb, ed, eb, eo, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
